// File: rtl/frog_controller_if.sv
// Purpose: bundles the player-side signals between the frog controller and
//          keyboard decode, lane/collision logic and the game FSM.
// Ports:   master = frog_controller (drives positions, active_frog, dead_frog);
//          slave  = surrounding logic (drives keycode, hazard, win/lose).
interface frog_controller_if;
    logic [7:0]  keycode;
    logic        hazard;
    logic        win_game;
    logic        lose_game;
    logic [10:0] Frog1_X;
    logic [10:0] Frog1_Y;
    logic [10:0] Frog2_X;
    logic [10:0] Frog2_Y;
    logic [10:0] Frog3_X;
    logic [10:0] Frog3_Y;
    logic [1:0]  active_frog;
    logic        dead_frog;

    modport master (
        input  keycode, hazard, win_game, lose_game,
        output Frog1_X, Frog1_Y, Frog2_X, Frog2_Y, Frog3_X, Frog3_Y,
        output active_frog, dead_frog
    );

    modport slave (
        output keycode, hazard, win_game, lose_game,
        input  Frog1_X, Frog1_Y, Frog2_X, Frog2_Y, Frog3_X, Frog3_Y,
        input  active_frog, dead_frog
    );
endinterface

// File: rtl/frog_controller.sv
// Purpose: owns the three frogs' positions, turns keypresses into one-step hops,
//          detects deaths (hazard or bad home-row landing) and freezes on win/lose.
// Latency: every output is registered; an input seen at edge N shows at edge N.
//          No backpressure: one decision per frame_clk edge, inputs sampled each frame.
// Ports:   frame_clk, game_restart_n (async active-low) plain; everything else via
//          frog_controller_if.master (keycode/hazard/win/lose in, positions/active/dead out).
module frog_controller #(
    parameter int unsigned STEP       = 40,
    parameter int unsigned START_X    = 320,
    parameter int unsigned START_Y    = 440,
    parameter int unsigned HOME_Y     = 40,
    parameter int unsigned HOME_X0    = 120,
    parameter int unsigned HOME_X1    = 280,
    parameter int unsigned HOME_X2    = 480,
    parameter int unsigned X_MAX      = 600,
    parameter int unsigned Y_MAX      = 440,
    parameter int unsigned PARK_XY    = 1000,
    parameter int unsigned DEATH_HOLD = 30
) (
    input  logic               frame_clk,
    input  logic               game_restart_n,
    frog_controller_if.master  bus
);

    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [10:0] START_X_W = 11'(START_X);
    localparam logic [10:0] START_Y_W = 11'(START_Y);
    localparam logic [10:0] HOME_Y_W  = 11'(HOME_Y);
    localparam logic [10:0] HOME_X0_W = 11'(HOME_X0);
    localparam logic [10:0] HOME_X1_W = 11'(HOME_X1);
    localparam logic [10:0] HOME_X2_W = 11'(HOME_X2);
    localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_W   = 11'(Y_MAX);
    localparam logic [10:0] PARK_W    = 11'(PARK_XY);
    localparam logic [7:0]  HOLD_INIT = 8'(DEATH_HOLD - 1);

    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;

    typedef enum logic [1:0] {SPAWN, PLAY, DYING, DONE} state_t;

    state_t           state_q;
    logic [2:0][10:0] x_q;
    logic [2:0][10:0] y_q;
    logic [1:0]       active_q;
    logic [2:0]       occupied_q;
    logic             dead_q;
    logic [7:0]       key_prev_q;
    logic [7:0]       hold_q;

    logic             key_press_d;
    logic [10:0]      cur_x_d;
    logic [10:0]      cur_y_d;
    logic             slot_hit_d;
    logic [1:0]       slot_idx_d;

    // A keypress is an edge on the keycode, so a held key hops exactly once.
    assign key_press_d = (bus.keycode != 8'h00) && (bus.keycode != key_prev_q);
    assign cur_x_d     = x_q[active_q];
    assign cur_y_d     = y_q[active_q];

    always_comb begin
        slot_hit_d = 1'b0;
        slot_idx_d = 2'd0;
        if (cur_x_d == HOME_X0_W) begin
            slot_hit_d = 1'b1;
            slot_idx_d = 2'd0;
        end else if (cur_x_d == HOME_X1_W) begin
            slot_hit_d = 1'b1;
            slot_idx_d = 2'd1;
        end else if (cur_x_d == HOME_X2_W) begin
            slot_hit_d = 1'b1;
            slot_idx_d = 2'd2;
        end
    end

    always_ff @(posedge frame_clk or negedge game_restart_n) begin
        if (!game_restart_n) begin
            state_q    <= SPAWN;
            x_q        <= {3{PARK_W}};
            y_q        <= {3{PARK_W}};
            active_q   <= 2'd0;
            occupied_q <= 3'b000;
            dead_q     <= 1'b0;
            key_prev_q <= 8'h00;
            hold_q     <= 8'd0;
        end else begin
            key_prev_q <= bus.keycode;
            dead_q     <= 1'b0;
            if (bus.win_game || bus.lose_game) begin
                state_q <= DONE;
            end else begin
                case (state_q)
                    SPAWN: begin
                        x_q[active_q] <= START_X_W;
                        y_q[active_q] <= START_Y_W;
                        state_q       <= PLAY;
                    end
                    PLAY: begin
                        if (bus.hazard) begin
                            // Death wins over any keypress in the same frame.
                            dead_q  <= 1'b1;
                            hold_q  <= HOLD_INIT;
                            state_q <= DYING;
                        end else if (key_press_d) begin
                            // Bounds are checked before the subtraction so nothing wraps.
                            case (bus.keycode)
                                KEY_LEFT: begin
                                    if (cur_x_d >= STEP_W)
                                        x_q[active_q] <= cur_x_d - STEP_W;
                                end
                                KEY_RIGHT: begin
                                    if (cur_x_d <= X_MAX_W - STEP_W)
                                        x_q[active_q] <= cur_x_d + STEP_W;
                                end
                                KEY_DOWN: begin
                                    if (cur_y_d <= Y_MAX_W - STEP_W)
                                        y_q[active_q] <= cur_y_d + STEP_W;
                                end
                                KEY_UP: begin
                                    if (cur_y_d > HOME_Y_W + STEP_W) begin
                                        y_q[active_q] <= cur_y_d - STEP_W;
                                    end else if (cur_y_d == HOME_Y_W + STEP_W) begin
                                        if (slot_hit_d && !occupied_q[slot_idx_d]) begin
                                            // X already equals the slot X; only Y moves.
                                            y_q[active_q]          <= HOME_Y_W;
                                            occupied_q[slot_idx_d] <= 1'b1;
                                            if (active_q == 2'd2) begin
                                                state_q <= DONE;
                                            end else begin
                                                active_q <= active_q + 2'd1;
                                                state_q  <= SPAWN;
                                            end
                                        end else begin
                                            // Missed or taken slot: die at pre-hop spot.
                                            dead_q  <= 1'b1;
                                            hold_q  <= HOLD_INIT;
                                            state_q <= DYING;
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    DYING: begin
                        if (hold_q == 8'd0)
                            state_q <= SPAWN;
                        else
                            hold_q <= hold_q - 8'd1;
                    end
                    DONE: ;
                    default: state_q <= DONE;
                endcase
            end
        end
    end

    assign bus.Frog1_X     = x_q[0];
    assign bus.Frog1_Y     = y_q[0];
    assign bus.Frog2_X     = x_q[1];
    assign bus.Frog2_Y     = y_q[1];
    assign bus.Frog3_X     = x_q[2];
    assign bus.Frog3_Y     = y_q[2];
    assign bus.active_frog = active_q;
    assign bus.dead_frog   = dead_q;

endmodule

// File: tb/tb_frog_controller.sv
// Purpose: directed self-checking bench for frog_controller.
// Latency: outputs sampled 1 time unit after each frame_clk rising edge.
// Ports:   drives the slave side of frog_controller_if; clk/reset are plain signals.
module tb_frog_controller;
    localparam logic [7:0] UP    = 8'h1A;
    localparam logic [7:0] DOWN  = 8'h16;
    localparam logic [7:0] LEFT  = 8'h04;
    localparam logic [7:0] RIGHT = 8'h07;

    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    frog_controller_if ifc();

    frog_controller dut (
        .frame_clk      (clk),
        .game_restart_n (rst_n),
        .bus            (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press-and-release: one frame with the key, one frame idle.
    task automatic press(input logic [7:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            ifc.keycode = code;
            step(1);
            ifc.keycode = 8'h00;
            step(1);
        end
    endtask

    function automatic logic [10:0] fx(input int idx);
        case (idx)
            0:       return ifc.Frog1_X;
            1:       return ifc.Frog2_X;
            default: return ifc.Frog3_X;
        endcase
    endfunction

    function automatic logic [10:0] fy(input int idx);
        case (idx)
            0:       return ifc.Frog1_Y;
            1:       return ifc.Frog2_Y;
            default: return ifc.Frog3_Y;
        endcase
    endfunction

    // Caller has set up the killing inputs; checks pulse, freeze and respawn timing.
    task automatic death_seq(input string tag, input int idx,
                             input logic [10:0] hx, input logic [10:0] hy);
        step(1);
        chk({tag, "_dead_pulse"}, ifc.dead_frog, 1);
        chk({tag, "_held_x"}, fx(idx), hx);
        chk({tag, "_held_y"}, fy(idx), hy);
        ifc.keycode = 8'h00;
        ifc.hazard  = 1'b0;
        step(1);
        chk({tag, "_dead_one_frame"}, ifc.dead_frog, 0);
        step(29);
        chk({tag, "_frozen_y"}, fy(idx), hy);
        step(1);
        chk({tag, "_respawn_x"}, fx(idx), 320);
        chk({tag, "_respawn_y"}, fy(idx), 440);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        ifc.keycode   = 8'h00;
        ifc.hazard    = 1'b0;
        ifc.win_game  = 1'b0;
        ifc.lose_game = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // T1 reset and first spawn
        chk("rst_f1x", ifc.Frog1_X, 1000);
        chk("rst_f1y", ifc.Frog1_Y, 1000);
        chk("rst_active", ifc.active_frog, 0);
        chk("rst_dead", ifc.dead_frog, 0);
        #1 rst_n = 1'b1;
        step(1);
        chk("t1_f1x", ifc.Frog1_X, 320);
        chk("t1_f1y", ifc.Frog1_Y, 440);
        chk("t1_f2x", ifc.Frog2_X, 1000);
        chk("t1_f3y", ifc.Frog3_Y, 1000);
        chk("t1_active", ifc.active_frog, 0);

        // T2 held key hops once, then walk into a non-slot home column
        ifc.keycode = UP;
        step(5);
        chk("t2_hold_y", ifc.Frog1_Y, 400);
        ifc.keycode = 8'h00;
        step(1);
        press(UP, 8);
        chk("t2_walk_y", ifc.Frog1_Y, 80);
        chk("t2_no_dead", ifc.dead_frog, 0);
        ifc.keycode = UP;
        death_seq("t2", 0, 320, 80);
        chk("t2_active", ifc.active_frog, 0);

        // T3 land frog 1 in slot 280, then frog 2 dies on the taken slot
        press(LEFT, 1);
        press(UP, 9);
        chk("t3_pre_x", ifc.Frog1_X, 280);
        chk("t3_pre_y", ifc.Frog1_Y, 80);
        ifc.keycode = UP;
        step(1);
        chk("t3_land_x", ifc.Frog1_X, 280);
        chk("t3_land_y", ifc.Frog1_Y, 40);
        chk("t3_active", ifc.active_frog, 1);
        chk("t3_f2_parked", ifc.Frog2_X, 1000);
        ifc.keycode = 8'h00;
        step(1);
        chk("t3_f2_x", ifc.Frog2_X, 320);
        chk("t3_f2_y", ifc.Frog2_Y, 440);
        press(LEFT, 1);
        press(UP, 9);
        ifc.keycode = UP;
        death_seq("t3_taken", 1, 280, 80);
        chk("t3_f1_stays", ifc.Frog1_Y, 40);

        // T4 hazard with a simultaneous keypress
        press(UP, 1);
        chk("t4_pre_y", ifc.Frog2_Y, 400);
        ifc.keycode = LEFT;
        ifc.hazard  = 1'b1;
        death_seq("t4", 1, 320, 400);

        // T5 edge-of-field hops are ignored
        ifc.keycode = DOWN;
        step(1);
        chk("t5_down_y", ifc.Frog2_Y, 440);
        chk("t5_down_dead", ifc.dead_frog, 0);
        ifc.keycode = 8'h00;
        step(1);
        press(LEFT, 8);
        chk("t5_x0", ifc.Frog2_X, 0);
        ifc.keycode = LEFT;
        step(1);
        chk("t5_left_x", ifc.Frog2_X, 0);
        chk("t5_left_dead", ifc.dead_frog, 0);
        ifc.keycode = 8'h00;
        step(1);
        press(RIGHT, 15);
        chk("t5_x600", ifc.Frog2_X, 600);
        ifc.keycode = RIGHT;
        step(1);
        chk("t5_right_x", ifc.Frog2_X, 600);
        chk("t5_right_dead", ifc.dead_frog, 0);
        ifc.keycode = 8'h00;
        step(1);

        // T6 fill slots 120 and 480 to finish the game
        press(LEFT, 12);
        press(UP, 10);
        chk("t6_f2_y", ifc.Frog2_Y, 40);
        chk("t6_f2_x", ifc.Frog2_X, 120);
        chk("t6_active", ifc.active_frog, 2);
        chk("t6_f3_x", ifc.Frog3_X, 320);
        press(RIGHT, 4);
        press(UP, 10);
        chk("t6_f1_y", ifc.Frog1_Y, 40);
        chk("t6_f3_y", ifc.Frog3_Y, 40);
        chk("t6_f3_x480", ifc.Frog3_X, 480);
        press(DOWN, 1);
        chk("t6_done_frozen", ifc.Frog3_Y, 40);
        chk("t6_done_active", ifc.active_frog, 2);

        // lose_game during DYING freezes play, no respawn
        rst_n = 1'b0;
        #1;
        chk("t6_rst_f3y", ifc.Frog3_Y, 1000);
        chk("t6_rst_active", ifc.active_frog, 0);
        rst_n = 1'b1;
        step(1);
        press(UP, 1);
        ifc.hazard = 1'b1;
        step(1);
        chk("t6_dying_dead", ifc.dead_frog, 1);
        ifc.hazard = 1'b0;
        step(5);
        ifc.lose_game = 1'b1;
        step(1);
        ifc.lose_game = 1'b0;
        step(40);
        chk("t6_lose_y", ifc.Frog1_Y, 400);
        chk("t6_lose_dead", ifc.dead_frog, 0);

        // reset in the middle of play acts immediately
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step(1);
        ifc.keycode = UP;
        step(1);
        chk("t6_hop_y", ifc.Frog1_Y, 400);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_y", ifc.Frog1_Y, 1000);
        chk("t6_async_x", ifc.Frog1_X, 1000);
        ifc.keycode = 8'h00;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
